sample_history_buf: RTL and testbench

- Parametrised successor to the fixed 10x8 sample shift register in the temperature logger.
- Holds the last DEPTH samples from the SPI sensor path, newest at index 0.
- Tracks fill level and a running sum for moving-average use.
- On request, streams the stored history oldest-first to the UART formatter over a valid/ready handshake.

---
 rtl/sample_history_buf_pkg.sv | 9 +
 rtl/sample_history_rd_fsm.sv | 80 ++++++++
 rtl/sample_history_buf.sv | 109 ++++++++++
 tb/tb_sample_history_buf.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sample_history_buf_pkg.sv
// Shared types for the sample history buffer: readout FSM state encoding.
package sample_history_buf_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DUMP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/sample_history_rd_fsm.sv
// Readout sequencer: walks the frozen history oldest-first and produces
// the valid/last/done qualifiers for the output stream.
module sample_history_rd_fsm
  import sample_history_buf_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             dump_start_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] idx_o,
  output logic             out_valid_o,
  output logic             out_last_o,
  output logic             dump_done_o,
  output rd_state_e        state_o
);

  // Handshake: a beat transfers on a rising edge where out_valid_o and
  // out_ready_i are both high; out_valid_o never drops before that transfer.
  rd_state_e        state_q;
  logic [CNT_W-1:0] idx_q;
  logic             valid_q;
  logic             last_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_q <= RD_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RD_IDLE: begin
          if (dump_start_i) begin
            // count_i is the post-push count, so a same-cycle push is included
            if (count_i != '0) begin
              state_q <= RD_DUMP;
              idx_q   <= count_i - CNT_W'(1);
              valid_q <= 1'b1;
              last_q  <= (count_i == CNT_W'(1));
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RD_DUMP: begin
          if (valid_q && out_ready_i) begin
            if (idx_q == '0) begin
              state_q <= RD_IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= idx_q - CNT_W'(1);
              last_q <= (idx_q == CNT_W'(1));
            end
          end
        end
        default: begin
          state_q <= RD_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign idx_o       = idx_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign dump_done_o = done_q;
  assign state_o     = state_q;

endmodule

// File: rtl/sample_history_buf.sv
// Last-DEPTH sample history (newest at entry 0) with fill count, running sum
// and an oldest-first readout stream.
module sample_history_buf
  import sample_history_buf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int SUM_W = WIDTH + $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  input  logic                   clear,
  input  logic                   dump_start,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   dump_busy,
  output logic                   dump_done,
  output logic [CNT_W-1:0]       count,
  output logic [SUM_W-1:0]       sum,
  output logic                   dropped,
  output logic [WIDTH*DEPTH-1:0] hist_flat
);

  logic [WIDTH-1:0] hist_q [DEPTH];
  logic [WIDTH-1:0] hist_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             dropped_q, dropped_d;
  logic             full;
  logic             push_ok;
  logic [CNT_W-1:0] rd_idx;
  rd_state_e        rd_state;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = in_valid && (rd_state == RD_IDLE);

  always_comb begin
    hist_d    = hist_q;
    count_d   = count_q;
    sum_d     = sum_q;
    dropped_d = dropped_q;
    if (push_ok) begin
      hist_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      count_d = full ? count_q : count_q + CNT_W'(1);
      // Once full, the oldest sample falls off the end and leaves the sum
      sum_d   = sum_q + SUM_W'(in_data) - (full ? SUM_W'(hist_q[DEPTH-1]) : '0);
    end else if (in_valid) begin
      dropped_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
      count_q   <= '0;
      sum_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      dropped_q <= dropped_d;
    end
  end

  sample_history_rd_fsm #(
    .CNT_W (CNT_W)
  ) u_rd_fsm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear),
    .dump_start_i (dump_start),
    .count_i      (count_d),
    .out_ready_i  (out_ready),
    .idx_o        (rd_idx),
    .out_valid_o  (out_valid),
    .out_last_o   (out_last),
    .dump_done_o  (dump_done),
    .state_o      (rd_state)
  );

  // Storage is frozen during a dump, so this mux is stable while stalled
  always_comb begin
    out_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == CNT_W'(i)) out_data = hist_q[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign hist_flat[g*WIDTH +: WIDTH] = hist_q[g];
  end

  assign dump_busy = (rd_state == RD_DUMP);
  assign count     = count_q;
  assign sum       = sum_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_sample_history_buf.sv
// Bench for sample_history_buf: fixed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_sample_history_buf;

  localparam int WIDTH = 8;
  localparam int DEPTH = 10;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = WIDTH + $clog2(DEPTH);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   clear;
  logic                   dump_start;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic                   dump_busy;
  logic                   dump_done;
  logic [CNT_W-1:0]       count;
  logic [SUM_W-1:0]       sum;
  logic                   dropped;
  logic [WIDTH*DEPTH-1:0] hist_flat;

  sample_history_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .clear(clear), .dump_start(dump_start), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .dump_busy(dump_busy), .dump_done(dump_done), .count(count),
    .sum(sum), .dropped(dropped), .hist_flat(hist_flat)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: history newest-first, expected readout oldest-first
  logic [WIDTH-1:0] m_hist[$];
  logic [WIDTH-1:0] exp_q[$];
  bit               m_dump;
  bit               m_done;
  bit               m_drop;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit v, input logic [WIDTH-1:0] d,
                            input bit ds, input bit rdy);
    bit was_dump;
    if (r || c) begin
      m_hist.delete(); exp_q.delete();
      m_dump = 0; m_done = 0; m_drop = 0;
      return;
    end
    m_done   = 0;
    was_dump = m_dump;
    if (v) begin
      if (was_dump) m_drop = 1;
      else begin
        m_hist.push_front(d);
        if (m_hist.size() > DEPTH) m_hist.delete(m_hist.size() - 1);
      end
    end
    if (was_dump) begin
      if (rdy) begin
        exp_q.delete(0);
        if (exp_q.size() == 0) begin m_dump = 0; m_done = 1; end
      end
    end else if (ds) begin
      if (m_hist.size() > 0) begin
        exp_q.delete();
        for (int i = m_hist.size() - 1; i >= 0; i--) exp_q.push_back(m_hist[i]);
        m_dump = 1;
      end else m_done = 1;
    end
  endtask

  task automatic check_model();
    logic [WIDTH*DEPTH-1:0] eh;
    int es;
    eh = '0; es = 0;
    for (int i = 0; i < m_hist.size(); i++) begin
      eh[i*WIDTH +: WIDTH] = m_hist[i];
      es += int'(m_hist[i]);
    end
    chk("m_count", count, m_hist.size());
    chk("m_sum", sum, es);
    chk("m_hist", hist_flat, eh);
    chk("m_valid", out_valid, m_dump);
    chk("m_busy", dump_busy, m_dump);
    chk("m_last", out_last, m_dump && exp_q.size() == 1);
    chk("m_done", dump_done, m_done);
    chk("m_dropped", dropped, m_drop);
    if (m_dump) chk("m_data", out_data, exp_q[0]);
  endtask

  // driver: inputs change on the falling edge, outputs checked one cycle later
  task automatic apply(input bit r, input bit c, input bit v, input logic [WIDTH-1:0] d,
                       input bit ds, input bit rdy);
    rst = r; clear = c; in_valid = v; in_data = d; dump_start = ds; out_ready = rdy;
    model_step(r, c, v, d, ds, rdy);
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit rst, clr, vld;
    logic [7:0] d;
    bit ds, rdy;
    int cnt, sm;
    bit v, l;
    logic [7:0] od;
    bit dn, drp;
    logic [23:0] h;
  } vec_t;

  function automatic vec_t mk(bit r, bit c, bit v, logic [7:0] d, bit ds, bit rdy,
                              int cnt, int sm, bit ov, bit ol, logic [7:0] od,
                              bit dn, bit drp, logic [23:0] h);
    vec_t t;
    t.rst = r; t.clr = c; t.vld = v; t.d = d; t.ds = ds; t.rdy = rdy;
    t.cnt = cnt; t.sm = sm; t.v = ov; t.l = ol; t.od = od; t.dn = dn; t.drp = drp; t.h = h;
    return t;
  endfunction

  vec_t tbl[13];

  initial begin
    rst = 1; clear = 0; in_valid = 0; in_data = '0; dump_start = 0; out_ready = 0;
    m_dump = 0; m_done = 0; m_drop = 0;

    //              rst clr vld d      ds rdy cnt sum   v  l  od     dn drp hist[2:0]
    tbl[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 'h00, 0, 0, 8'h00, 0, 0, 24'h000000);
    tbl[1]  = mk(0, 0, 1, 8'h11, 0, 0, 1, 'h11, 0, 0, 8'h00, 0, 0, 24'h000011);
    tbl[2]  = mk(0, 0, 1, 8'h22, 0, 0, 2, 'h33, 0, 0, 8'h00, 0, 0, 24'h001122);
    tbl[3]  = mk(0, 0, 1, 8'h33, 0, 0, 3, 'h66, 0, 0, 8'h00, 0, 0, 24'h112233);
    tbl[4]  = mk(0, 0, 0, 8'h00, 1, 0, 3, 'h66, 1, 0, 8'h11, 0, 0, 24'h112233);
    tbl[5]  = mk(0, 0, 0, 8'h00, 0, 1, 3, 'h66, 1, 0, 8'h22, 0, 0, 24'h112233);
    tbl[6]  = mk(0, 0, 0, 8'h00, 0, 0, 3, 'h66, 1, 0, 8'h22, 0, 0, 24'h112233);
    tbl[7]  = mk(0, 0, 1, 8'h44, 0, 1, 3, 'h66, 1, 1, 8'h33, 0, 1, 24'h112233);
    tbl[8]  = mk(0, 0, 0, 8'h00, 0, 1, 3, 'h66, 0, 0, 8'h00, 1, 1, 24'h112233);
    tbl[9]  = mk(0, 0, 0, 8'h00, 0, 0, 3, 'h66, 0, 0, 8'h00, 0, 1, 24'h112233);
    tbl[10] = mk(0, 1, 0, 8'h00, 0, 0, 0, 'h00, 0, 0, 8'h00, 0, 0, 24'h000000);
    tbl[11] = mk(0, 0, 0, 8'h00, 1, 1, 0, 'h00, 0, 0, 8'h00, 1, 0, 24'h000000);
    tbl[12] = mk(0, 0, 0, 8'h00, 0, 1, 0, 'h00, 0, 0, 8'h00, 0, 0, 24'h000000);

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].rst, tbl[i].clr, tbl[i].vld, tbl[i].d, tbl[i].ds, tbl[i].rdy);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_sum", i), sum, tbl[i].sm);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].v);
      chk($sformatf("tbl%0d_last", i), out_last, tbl[i].l);
      chk($sformatf("tbl%0d_done", i), dump_done, tbl[i].dn);
      chk($sformatf("tbl%0d_dropped", i), dropped, tbl[i].drp);
      chk($sformatf("tbl%0d_hist", i), hist_flat[23:0], tbl[i].h);
      if (tbl[i].v) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].od);
    end
    chk("tbl_hist_upper_zero", hist_flat[WIDTH*DEPTH-1:24], '0);

    // overfill: 12 pushes into a 10-deep history
    for (int i = 1; i <= 12; i++) apply(0, 0, 1, 8'(i), 0, 0);
    chk("fill_count", count, 10);
    chk("fill_sum", sum, 75);
    chk("fill_entry9", hist_flat[9*WIDTH +: WIDTH], 8'd3);
    chk("fill_entry0", hist_flat[7:0], 8'd12);

    // clear after the first of three beats: abort without dump_done
    apply(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 8'(8'hA0 + i), 0, 0);
    apply(0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 1);
    chk("abort_data_2nd", out_data, 8'hA1);
    apply(0, 1, 0, 0, 0, 1);
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_count", count, 0);
    chk("abort_sum", sum, 0);
    chk("abort_done", dump_done, 1'b0);
    apply(0, 0, 0, 0, 0, 1);
    chk("abort_done_late", dump_done, 1'b0);

    // empty dump request, then reset in the middle of a dump
    apply(0, 0, 0, 0, 1, 1);
    chk("empty_done", dump_done, 1'b1);
    chk("empty_valid", out_valid, 1'b0);
    apply(0, 0, 1, 8'h5A, 0, 0);
    apply(0, 0, 1, 8'hC3, 1, 0);
    chk("pushdump_busy", dump_busy, 1'b1);
    chk("pushdump_data", out_data, 8'h5A);
    apply(1, 0, 0, 0, 0, 1);
    chk("rst_outputs", {out_valid, out_last, dump_busy, dump_done, dropped, count, sum}, '0);
    chk("rst_hist", hist_flat, '0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      apply($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
